// File: rtl/id_pkg.sv
// Shared types and constants for the ID character framer and its decoder.
package id_pkg;

    typedef enum logic [1:0] {
        COLLECT,
        EMIT,
        GAP
    } state_t;

    typedef enum logic [1:0] {
        POS_FIRST,
        POS_SECOND,
        POS_REST
    } pos_t;

    localparam int ID_LEN = 10;
    localparam int ID_W   = 6;

    localparam logic [7:0] CH_A = 8'h41;
    localparam logic [7:0] CH_Z = 8'h5A;
    localparam logic [7:0] CH_a = 8'h61;
    localparam logic [7:0] CH_z = 8'h7A;
    localparam logic [7:0] CH_0 = 8'h30;
    localparam logic [7:0] CH_1 = 8'h31;
    localparam logic [7:0] CH_2 = 8'h32;
    localparam logic [7:0] CH_9 = 8'h39;

endpackage

// File: rtl/id_char_decode.sv
// Combinational per-position format check and ASCII-to-code mapping.
// Build option ID_LOWERCASE_EN: the first position also accepts 'a'..'z'.
module id_char_decode
    import id_pkg::*;
(
    input  logic [7:0]      char_data,
    input  pos_t            pos,
    output logic [ID_W-1:0] code,
    output logic            legal
);

    always_comb begin
        code  = '0;
        legal = 1'b0;
        case (pos)
            POS_FIRST: begin
                if (char_data >= CH_A && char_data <= CH_Z) begin
                    legal = 1'b1;
                    code  = ID_W'(char_data - CH_A);
                end
`ifdef ID_LOWERCASE_EN
                else if (char_data >= CH_a && char_data <= CH_z) begin
                    legal = 1'b1;
                    code  = ID_W'(char_data - CH_a);
                end
`endif
            end
            POS_SECOND: begin
                if (char_data == CH_1 || char_data == CH_2) begin
                    legal = 1'b1;
                    code  = ID_W'(char_data - CH_0);
                end
            end
            default: begin
                if (char_data >= CH_0 && char_data <= CH_9) begin
                    legal = 1'b1;
                    code  = ID_W'(char_data - CH_0);
                end
            end
        endcase
    end

endmodule

// File: rtl/id_char_framer.sv
// Buffers one 10-character ID, drops malformed frames, and replays good ones
// as a contiguous 10-cycle code burst followed by a forced idle gap.
//
// state   | meaning
// COLLECT | accepting characters, rx_cnt = next position
// EMIT    | driving buf[tx_cnt] on out_id, out_valid high
// GAP     | forced idle for GAP_CYCLES cycles before next frame
module id_char_framer
    import id_pkg::*;
#(
    parameter int GAP_CYCLES = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             char_valid,
    input  logic [7:0]       char_data,
    output logic             char_ready,
    output logic             out_valid,
    output logic [ID_W-1:0]  out_id,
    output logic             fmt_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [3:0] LAST_POS = 4'(ID_LEN - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t          state;
    logic [3:0]      rx_cnt;
    logic [3:0]      tx_cnt;
    logic [3:0]      gap_cnt;
    pos_t            pos;
    logic [ID_W-1:0] code;
    logic            legal;
    logic            accept;
    logic [ID_W-1:0] id_buf [ID_LEN];

    assign char_ready = (state == COLLECT);
    assign accept     = char_valid && char_ready;

    always_comb begin
        pos = POS_REST;
        if (rx_cnt == 4'd0)
            pos = POS_FIRST;
        else if (rx_cnt == 4'd1)
            pos = POS_SECOND;
    end

    id_char_decode u_decode (
        .char_data (char_data),
        .pos       (pos),
        .code      (code),
        .legal     (legal)
    );

    // Buffer content is don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept && legal)
            id_buf[rx_cnt] <= code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            rx_cnt    <= '0;
            tx_cnt    <= '0;
            gap_cnt   <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            fmt_err   <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            fmt_err <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (!legal) begin
                            rx_cnt  <= '0;
                            fmt_err <= 1'b1;
                            if (err_cnt != '1)
                                err_cnt <= err_cnt + 1'b1;
                        end else if (rx_cnt == LAST_POS) begin
                            rx_cnt    <= '0;
                            tx_cnt    <= '0;
                            state     <= EMIT;
                            out_valid <= 1'b1;
                            out_id    <= id_buf[0];
                        end else begin
                            rx_cnt <= rx_cnt + 4'd1;
                        end
                    end
                end
                EMIT: begin
                    // out_id is staged one beat ahead so it lines up with tx_cnt.
                    if (tx_cnt == LAST_POS) begin
                        state     <= GAP;
                        gap_cnt   <= '0;
                        out_valid <= 1'b0;
                        out_id    <= '0;
                        frame_cnt <= frame_cnt + 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 4'd1;
                        out_id <= id_buf[tx_cnt + 4'd1];
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= COLLECT;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
